// File: rtl/adder_pipe.sv
// Segmented carry-pipelined adder/subtractor: SEG bits per stage, global stall,
// valid-ready handshake at both ends, carry and signed-overflow flags.
module adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  // Stage k holds the operand set with segments 0..k-1 already summed.
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             vld_p [STAGES];

  logic [SEG:0]     seg_p [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             advance;
  logic             ovf_nxt;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_p[k] = {1'b0, a_p[k][k*SEG +: SEG]} + {1'b0, b_p[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_p[k]};
      nxt_s[k] = s_p[k];
      nxt_s[k][k*SEG +: SEG] = seg_p[k][SEG-1:0];
    end
    ovf_nxt = signed_ovf(a_p[STAGES-1][WIDTH-1], b_p[STAGES-1][WIDTH-1],
                         nxt_s[STAGES-1][WIDTH-1]);
  end

  // Control: valid bits shift only on advance; reset wins and drops any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      out_valid <= vld_p[STAGES-1];
      // Final stage: top segment plus flags into the output registers.
      if (vld_p[STAGES-1]) begin
        sum  <= nxt_s[STAGES-1];
        cout <= seg_p[STAGES-1][SEG];
        ovf  <= ovf_nxt;
      end
    end
  end

  // Stage 0 captures the effective operands; later stages carry the skewed data.
  always_ff @(posedge clk) begin
    if (advance) begin
      a_p[0] <= a;
      b_p[0] <= sub ? ~b : b;
      c_p[0] <= sub ? 1'b1 : cin;
      s_p[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_p[k] <= a_p[k-1];
        b_p[k] <= b_p[k-1];
        s_p[k] <= nxt_s[k-1];
        c_p[k] <= seg_p[k-1][SEG];
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed-vector, stall, reset and random scoreboard bench for adder_pipe
// (WIDTH=16, SEG=4).
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  int   checks = 0;
  int   passed = 0;
  int   n_out  = 0;
  int   n_acc  = 0;
  res_t exp_q[$];
  logic stall_prev;
  res_t hold;
  vec_t vecs[10];

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    logic [15:0] be;
    logic [16:0] t;
    res_t        r;
    be   = sb ? ~y : y;
    t    = {1'b0, x} + {1'b0, be} + {16'b0, (sb ? 1'b1 : ci)};
    r.s  = t[15:0];
    r.co = t[16];
    r.ov = (x[15] == be[15]) && (t[15] != x[15]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // One clock cycle of streaming traffic with scoreboard bookkeeping.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic is, input logic ir, output logic acc);
    res_t e;
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ir;
    #1;
    acc = iv && in_ready && !rst;
    if (stall_prev) check("stall_hold", 32'({sum, cout, ovf}), 32'(hold));
    if (acc) begin
      exp_q.push_back(model(ia, ib, ic, is));
      n_acc++;
    end
    if (out_valid && ir && !rst) begin
      n_out++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      check("result", 32'({sum, cout, ovf}), 32'(e));
    end
    stall_prev = out_valid && !ir && !rst;
    hold       = {sum, cout, ovf};
    @(posedge clk); #1;
  endtask

  // Single isolated transaction: checks latency and result fields.
  task automatic apply_one(input vec_t v, input int idx);
    int lat;
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = 1'b1;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'd4);
    check($sformatf("vec%0d_sum", idx), 32'(sum), 32'(v.s));
    check($sformatf("vec%0d_cout", idx), 32'(cout), 32'(v.co));
    check($sformatf("vec%0d_ovf", idx), 32'(ovf), 32'(v.ov));
    @(posedge clk); #1;
  endtask

  initial begin
    logic acc;
    int   idx, n0;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0; stall_prev = 1'b0; hold = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 10; i++) apply_one(vecs[i], i);

    // Back-to-back stream of 8 with a 3-cycle downstream stall.
    idx = 0; n_out = 0; n_acc = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc >= 6 && cyc <= 8) begin
        out_ready = 1'b0;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
      end
      cycle(idx < 8, 16'(idx * 16'h1357), 16'(16'hF00F ^ (idx << 4)),
            (idx % 2) == 1, (idx % 3) == 0, !(cyc >= 6 && cyc <= 8), acc);
      if (acc) idx++;
    end
    check("stream_accepted", 32'(n_acc), 32'd8);
    check("stream_count", 32'(n_out), 32'd8);
    check("stream_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three operations in flight plus a coincident handshake.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1000 + 16'(i), 16'h0100, 1'b0, 1'b0, 1'b1, acc);
    rst = 1'b1;
    cycle(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b0, 1'b1, acc);
    rst = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    n0 = n_out;
    repeat (6) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    check("midrst_no_stale", 32'(n_out), 32'(n0));
    apply_one(vecs[2], 99);

    // Random traffic against the reference model.
    n_out = 0; n_acc = 0; stall_prev = 1'b0;
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(0, 99) < 70, 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 70, acc);
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    check("random_count", 32'(n_out), 32'(n_acc));
    check("random_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
